gain_channel_scheduler: RTL and testbench
=========================================

Name: gain_channel_scheduler

Overview:
- Time-shares one variable-gain datapath among NUM_CH audio channels (drum pads and mics).
- Captures each channel's 12-bit sample strobe and grants channels round-robin.
- Drives the datapath start/sample/gain inputs, waits for its done, and writes the result back to a per-channel output register with a one-cycle valid pulse.
- Sits between the ADC sample front end and the mixer/analysis stage.

Parameters:
- NUM_CH, 4: number of requesting channels (2..8).
- TIMEOUT_CYCLES, 15: max cycles in WAIT_DONE before abort.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- ch_sample_valid  in  NUM_CH  per-channel one-cycle sample strobe.
- ch_sample  in  NUM_CH*12  per-channel sample; channel i at [12i+11:12i].
- ch_gain  in  NUM_CH*9  per-channel signed gain code, 2's complement.
- gu_start  out  1  one-cycle start to the gain datapath.
- gu_sample  out  12  sample presented to the datapath.
- gu_gain  out  9  gain code presented to the datapath.
- gu_result  in  12  datapath output sample.
- gu_done  in  1  datapath done level.
- out_valid  out  NUM_CH  one-cycle pulse per channel when out_sample updates.
- out_sample  out  NUM_CH*12  registered processed sample per channel.
- overrun  out  NUM_CH  sticky: a new sample arrived while the previous one was still pending.
- timeout_err  out  1  sticky: datapath failed to return done.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, reset_n=0):
  - All outputs go to 0 immediately: gu_start, gu_sample, gu_gain, out_valid, out_sample, overrun, timeout_err, busy.
  - pending bits and holding registers cleared; round-robin pointer = 0; state = IDLE.
  - A reset mid-transaction drops the in-flight sample silently.
- Capture: on ch_sample_valid[i], hold[i] <= sample and pending[i] <= 1.
  - If pending[i] is already 1 and not granted that same cycle: overwrite hold[i] and set overrun[i].
  - A capture on the same cycle as that channel's grant re-sets pending; no overrun.
- State machine, 2-bit:
  - IDLE: if any pending, grant the first pending channel at or after rr_ptr (wrapping NUM_CH-1 -> 0). Latch gu_sample/gu_gain, clear pending[grant], set rr_ptr = grant+1 mod NUM_CH -> ISSUE.
  - ISSUE: gu_start=1 for exactly this cycle -> WAIT_DONE. Clear the timeout counter.
  - WAIT_DONE:
    - The first cycle ignores gu_done (stale done from the previous op).
    - After that, gu_done=1 -> WRITEBACK.
    - If the counter reaches TIMEOUT_CYCLES: set timeout_err, drop the sample, no out_valid -> IDLE.
  - WRITEBACK: out_sample[grant] <= gu_result; out_valid[grant]=1 for one cycle -> IDLE.
- gu_sample and gu_gain are held stable from ISSUE through WRITEBACK.
- Lone-channel latency: out_valid fires D+4 cycles after the capture edge, where D = cycles from the gu_start edge to gu_done high (D=4 for the current gain unit, so latency is 8).
- Throughput: one sample per D+4 cycles. A channel may be starved at most NUM_CH-1 grants.
- Simultaneous strobes on all channels: granted in round-robin order, no loss, no overrun.

Optional Feature:
- Macro GAIN_SCHED_RAMP_EN.
- Defined: each channel keeps cur_gain[i], reset to 0.
  - Each grant presents cur_gain[i] as gu_gain, then steps cur_gain[i] by +/-1 toward ch_gain[i], or holds when equal.
  - This gives zipper-free gain changes.
- Undefined: gu_gain = ch_gain[grant] sampled in IDLE; no per-channel gain state.

Decomposition:
- Package gain_sched_pkg:
  - SAMPLE_W=12, GAIN_W=9.
  - State encodings IDLE/ISSUE/WAIT_DONE/WRITEBACK.
  - Typedefs sample_t and gain_t.
- Sub-module rr_arbiter: parameterised NUM_CH.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, grant index, any_req.
  - Purely combinational.

Test Plan:
- Single channel 0: sample 0x400, gain 0, gain unit model D=4 returning 0x123 -> out_valid[0] pulses 8 cycles after capture; out_sample[0]=0x123; gu_start high exactly 1 cycle.
- All 4 channels strobed on the same cycle, rr_ptr=2 -> grant order 2,3,0,1; four out_valid pulses spaced 8 cycles apart; overrun=0.
- Channel 1 strobed twice 3 cycles apart while channel 0 is in flight -> overrun[1]=1; only the second sample is processed.
- Gain unit model never raises done -> timeout_err=1 after 15 WAIT_DONE cycles; no out_valid; next pending channel is then serviced normally.
- reset_n pulsed low during WAIT_DONE -> all outputs 0 in the same cycle; after release, new strobes are processed with rr_ptr=0.
- With GAIN_SCHED_RAMP_EN, ch_gain[0]=3 -> gu_gain on successive channel-0 grants is 0,1,2,3,3.

Source files
------------

// File: rtl/gain_sched_pkg.sv
// Shared types, widths and FSM encoding for the gain channel scheduler.
// Also holds the gain ramp step helper used when GAIN_SCHED_RAMP_EN is defined.
package gain_sched_pkg;

    localparam int SAMPLE_W = 12;
    localparam int GAIN_W   = 9;

    typedef logic        [SAMPLE_W-1:0] sample_t;
    typedef logic signed [GAIN_W-1:0]   gain_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_WRITEBACK = 2'd3
    } state_t;

    // Move one LSB toward the target so a gain change never jumps.
    function automatic gain_t ramp_step(input gain_t cur, input gain_t tgt);
        if (cur < tgt)
            return cur + gain_t'(1);
        else if (cur > tgt)
            return cur - gain_t'(1);
        else
            return cur;
    endfunction

endpackage

// File: rtl/gain_channel_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// i_ptr, wrapping from NUM_CH-1 back to 0.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic [NUM_CH-1:0] o_grant,
    output logic [IDX_W-1:0]  o_grant_idx,
    output logic              o_any_req
);

    logic w_found;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            int w_pos;
            w_pos = int'(i_ptr) + k;
            if (w_pos >= NUM_CH)
                w_pos = w_pos - NUM_CH;
            if (!w_found && i_req[w_pos]) begin
                w_found         = 1'b1;
                o_grant[w_pos]  = 1'b1;
                o_grant_idx     = IDX_W'(w_pos);
            end
        end
        o_any_req = |i_req;
    end

endmodule

// File: rtl/gain_channel_scheduler.sv
// Time-shares one variable-gain datapath among NUM_CH channels, round-robin.
// Optional macro GAIN_SCHED_RAMP_EN: per-channel gain ramps one LSB per grant.
module gain_channel_scheduler
    import gain_sched_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_CH-1:0]          ch_sample_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0] ch_sample,
    input  logic [NUM_CH*GAIN_W-1:0]   ch_gain,
    output logic                       gu_start,
    output logic [SAMPLE_W-1:0]        gu_sample,
    output logic [GAIN_W-1:0]          gu_gain,
    input  logic [SAMPLE_W-1:0]        gu_result,
    input  logic                       gu_done,
    output logic [NUM_CH-1:0]          out_valid,
    output logic [NUM_CH*SAMPLE_W-1:0] out_sample,
    output logic [NUM_CH-1:0]          overrun,
    output logic                       timeout_err,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [NUM_CH-1:0]   r_pending;
    logic [NUM_CH-1:0]   r_overrun;
    logic [NUM_CH-1:0]   r_out_valid;
    sample_t             r_hold       [NUM_CH];
    sample_t             r_out_sample [NUM_CH];
    gain_t               w_ch_gain    [NUM_CH];
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    r_grant_idx;
    logic [IDX_W-1:0]    w_grant_idx;
    logic [NUM_CH-1:0]   w_grant;
    logic [NUM_CH-1:0]   w_clear;
    logic                w_any_req;
    logic                w_take;
    logic                w_timeout;
    logic [CNT_W-1:0]    r_tcnt;
    sample_t             r_gu_sample;
    gain_t               r_gu_gain;
    logic                r_timeout_err;
`ifdef GAIN_SCHED_RAMP_EN
    gain_t               r_cur_gain   [NUM_CH];
`endif

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_arb (
        .i_req       (r_pending),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any_req   (w_any_req)
    );

    always_comb begin
        for (int i = 0; i < NUM_CH; i++)
            w_ch_gain[i] = gain_t'(ch_gain[i*GAIN_W +: GAIN_W]);
    end

    assign w_take  = (r_state == ST_IDLE) && w_any_req;
    assign w_clear = w_take ? w_grant : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    // r_tcnt == 0 marks the first WAIT_DONE cycle, where a stale done is ignored.
    always_comb begin
        w_next_state = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE:      if (w_any_req) w_next_state = ST_ISSUE;
            ST_ISSUE:     w_next_state = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if ((r_tcnt != '0) && gu_done) begin
                    w_next_state = ST_WRITEBACK;
                end else if (r_tcnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_next_state = ST_IDLE;
                    w_timeout    = 1'b1;
                end
            end
            ST_WRITEBACK: w_next_state = ST_IDLE;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pending     <= '0;
            r_overrun     <= '0;
            r_out_valid   <= '0;
            r_rr_ptr      <= '0;
            r_grant_idx   <= '0;
            r_tcnt        <= '0;
            r_gu_sample   <= '0;
            r_gu_gain     <= '0;
            r_timeout_err <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_hold[i]       <= '0;
                r_out_sample[i] <= '0;
`ifdef GAIN_SCHED_RAMP_EN
                r_cur_gain[i]   <= '0;
`endif
            end
        end else begin
            r_pending   <= (r_pending & ~w_clear) | ch_sample_valid;
            r_out_valid <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_sample_valid[i]) begin
                    r_hold[i] <= ch_sample[i*SAMPLE_W +: SAMPLE_W];
                    if (r_pending[i] && !w_clear[i])
                        r_overrun[i] <= 1'b1;
                end
            end
            if (w_take) begin
                r_grant_idx <= w_grant_idx;
                r_gu_sample <= r_hold[w_grant_idx];
                r_rr_ptr    <= (w_grant_idx == IDX_W'(NUM_CH - 1)) ? '0
                                                                 : w_grant_idx + IDX_W'(1);
`ifdef GAIN_SCHED_RAMP_EN
                r_gu_gain                <= r_cur_gain[w_grant_idx];
                r_cur_gain[w_grant_idx]  <= ramp_step(r_cur_gain[w_grant_idx],
                                                      w_ch_gain[w_grant_idx]);
`else
                r_gu_gain   <= w_ch_gain[w_grant_idx];
`endif
            end
            if (r_state == ST_ISSUE)
                r_tcnt <= '0;
            else if (r_state == ST_WAIT_DONE)
                r_tcnt <= r_tcnt + CNT_W'(1);
            if (w_timeout)
                r_timeout_err <= 1'b1;
            if (r_state == ST_WRITEBACK) begin
                r_out_sample[r_grant_idx] <= gu_result;
                r_out_valid               <= NUM_CH'(1) << r_grant_idx;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign out_sample[g*SAMPLE_W +: SAMPLE_W] = r_out_sample[g];
    end

    assign gu_start    = (r_state == ST_ISSUE);
    assign busy        = (r_state != ST_IDLE);
    assign gu_sample   = r_gu_sample;
    assign gu_gain     = r_gu_gain;
    assign out_valid   = r_out_valid;
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_gain_channel_scheduler.sv
// Directed bench for gain_channel_scheduler with a D=4 gain-unit model whose
// result is gu_sample ^ 0x523 ^ gain.
module tb_gain_channel_scheduler;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  ch_sample_valid = '0;
    logic [47:0] ch_sample = '0;
    logic [35:0] ch_gain = '0;
    logic        gu_start;
    logic [11:0] gu_sample;
    logic [8:0]  gu_gain;
    logic [11:0] gu_result = '0;
    logic        gu_done = 1'b0;
    logic [3:0]  out_valid;
    logic [47:0] out_sample;
    logic [3:0]  overrun;
    logic        timeout_err;
    logic        busy;

    int   vec = 0;
    int   err = 0;
    logic m_hang = 1'b0;
    int   m_cnt = 0;

    gain_channel_scheduler #(.NUM_CH(4), .TIMEOUT_CYCLES(15)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .ch_sample_valid (ch_sample_valid),
        .ch_sample       (ch_sample),
        .ch_gain         (ch_gain),
        .gu_start        (gu_start),
        .gu_sample       (gu_sample),
        .gu_gain         (gu_gain),
        .gu_result       (gu_result),
        .gu_done         (gu_done),
        .out_valid       (out_valid),
        .out_sample      (out_sample),
        .overrun         (overrun),
        .timeout_err     (timeout_err),
        .busy            (busy)
    );

    always #5 clock = ~clock;

    // Gain unit: done rises 4 edges after the start edge and stays high until next start.
    always @(posedge clock) begin
        if (gu_start) begin
            m_cnt   <= 4;
            gu_done <= 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1 && !m_hang) begin
                gu_done   <= 1'b1;
                gu_result <= gu_sample ^ 12'h523 ^ {3'b000, gu_gain};
            end
        end
    end

    function automatic logic [11:0] osamp(input int ch);
        return out_sample[ch*12 +: 12];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic strobe(input logic [3:0] mask);
        ch_sample_valid = mask;
        tick();
        ch_sample_valid = '0;
    endtask

    task automatic wait_pulse(input int max, output int k, output logic [3:0] ov);
        k  = -1;
        ov = '0;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (out_valid != '0) begin
                k  = i;
                ov = out_valid;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        vec++;
        if ({gu_start, gu_sample, gu_gain, out_valid, busy} !== '0) begin
            err++;
            $display("FAIL reset_ctrl: got %h required 0", {gu_start, gu_sample, gu_gain, out_valid, busy});
        end
        vec++;
        if ({out_sample, overrun, timeout_err} !== '0) begin
            err++;
            $display("FAIL reset_out: got %h required 0", {out_sample, overrun, timeout_err});
        end
        #2 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int k = -1;
        int nstart = 0;
        logic [3:0] ov = '0;
        ch_sample[0 +: 12] = 12'h400;
        strobe(4'b0001);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (gu_start) nstart++;
            if (out_valid != '0) begin
                k  = i;
                ov = out_valid;
                break;
            end
        end
        vec++;
        if (k !== 8) begin err++; $display("FAIL single_latency: got %0d required 8", k); end
        vec++;
        if (ov !== 4'b0001) begin err++; $display("FAIL single_valid: got %b required 0001", ov); end
        vec++;
        if (osamp(0) !== 12'h123) begin err++; $display("FAIL single_result: got %h required 123", osamp(0)); end
        vec++;
        if (nstart !== 1) begin err++; $display("FAIL single_start_cycles: got %0d required 1", nstart); end
        tick();
        vec++;
        if ({out_valid, busy} !== 5'b0) begin err++; $display("FAIL single_pulse_width: got %b required 00000", {out_valid, busy}); end
    endtask

    task automatic test_round_robin();
        int k;
        logic [3:0] ov;
        int          exp_ch  [4] = '{2, 3, 0, 1};
        logic [11:0] exp_val [4] = '{12'h623, 12'h5D3, 12'h423, 12'h723};
        ch_sample[12 +: 12] = 12'h011;
        strobe(4'b0010);
        wait_pulse(20, k, ov);
        vec++;
        if (ov !== 4'b0010 || osamp(1) !== 12'h532) begin
            err++;
            $display("FAIL rr_setup: got %b/%h required 0010/532", ov, osamp(1));
        end
        ch_sample = {12'h0F0, 12'h300, 12'h200, 12'h100};
        strobe(4'b1111);
        for (int p = 0; p < 4; p++) begin
            wait_pulse(12, k, ov);
            vec++;
            if (ov !== (4'b0001 << exp_ch[p]) || k !== 8) begin
                err++;
                $display("FAIL rr_order%0d: got valid %b after %0d required %b after 8", p, ov, k, 4'b0001 << exp_ch[p]);
            end
            vec++;
            if (osamp(exp_ch[p]) !== exp_val[p]) begin
                err++;
                $display("FAIL rr_value%0d: got %h required %h", p, osamp(exp_ch[p]), exp_val[p]);
            end
        end
        vec++;
        if (overrun !== 4'b0000) begin err++; $display("FAIL rr_overrun: got %b required 0000", overrun); end
    endtask

    task automatic test_overrun();
        int k;
        logic [3:0] ov;
        ch_sample[0 +: 12] = 12'h055;
        strobe(4'b0001);
        tick();
        ch_sample[12 +: 12] = 12'h0AA;
        strobe(4'b0010);
        tick();
        tick();
        ch_sample[12 +: 12] = 12'h0CC;
        strobe(4'b0010);
        wait_pulse(10, k, ov);
        vec++;
        if (ov !== 4'b0001 || osamp(0) !== 12'h576) begin
            err++;
            $display("FAIL ovr_ch0: got %b/%h required 0001/576", ov, osamp(0));
        end
        wait_pulse(12, k, ov);
        vec++;
        if (ov !== 4'b0010 || k !== 8 || osamp(1) !== 12'h5EF) begin
            err++;
            $display("FAIL ovr_ch1: got %b/%0d/%h required 0010/8/5ef", ov, k, osamp(1));
        end
        wait_pulse(12, k, ov);
        vec++;
        if (k !== -1) begin err++; $display("FAIL ovr_extra_pulse: got valid %b required none", ov); end
        vec++;
        if (overrun !== 4'b0010) begin err++; $display("FAIL ovr_flag: got %b required 0010", overrun); end
    endtask

    task automatic test_timeout();
        int k = -1;
        int pulses = 0;
        logic [3:0] ov;
        vec++;
        if (timeout_err !== 1'b0) begin err++; $display("FAIL tmo_pre: got %b required 0", timeout_err); end
        m_hang = 1'b1;
        ch_sample[36 +: 12] = 12'h333;
        ch_sample[0 +: 12]  = 12'h444;
        strobe(4'b1001);
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (out_valid != '0) pulses++;
            if (timeout_err) begin
                k = i;
                break;
            end
        end
        m_hang = 1'b0;
        vec++;
        if (k !== 17) begin err++; $display("FAIL tmo_cycle: got %0d required 17", k); end
        vec++;
        if (pulses !== 0) begin err++; $display("FAIL tmo_no_valid: got %0d pulses required 0", pulses); end
        wait_pulse(12, k, ov);
        vec++;
        if (ov !== 4'b0001 || k !== 8 || osamp(0) !== 12'h167) begin
            err++;
            $display("FAIL tmo_next: got %b/%0d/%h required 0001/8/167", ov, k, osamp(0));
        end
        vec++;
        if (osamp(3) !== 12'h5D3) begin err++; $display("FAIL tmo_dropped: got %h required 5d3", osamp(3)); end
    endtask

    task automatic test_reset_mid();
        int k;
        logic [3:0] ov;
        ch_sample[24 +: 12] = 12'h222;
        strobe(4'b0100);
        tick();
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        vec++;
        if ({gu_start, gu_sample, gu_gain, out_valid, busy, timeout_err} !== '0) begin
            err++;
            $display("FAIL rst_mid_ctrl: got %h required 0", {gu_start, gu_sample, gu_gain, out_valid, busy, timeout_err});
        end
        vec++;
        if ({out_sample, overrun} !== '0) begin
            err++;
            $display("FAIL rst_mid_out: got %h required 0", {out_sample, overrun});
        end
        tick();
        #2 reset_n = 1'b1;
        tick();
        ch_sample[12 +: 12] = 12'h0A0;
        ch_sample[36 +: 12] = 12'h0B0;
        strobe(4'b1010);
        wait_pulse(12, k, ov);
        vec++;
        if (ov !== 4'b0010 || k !== 8 || osamp(1) !== 12'h583) begin
            err++;
            $display("FAIL rst_first: got %b/%0d/%h required 0010/8/583", ov, k, osamp(1));
        end
        wait_pulse(12, k, ov);
        vec++;
        if (ov !== 4'b1000 || k !== 8 || osamp(3) !== 12'h593) begin
            err++;
            $display("FAIL rst_second: got %b/%0d/%h required 1000/8/593", ov, k, osamp(3));
        end
        vec++;
        if (osamp(2) !== 12'h000) begin err++; $display("FAIL rst_dropped: got %h required 000", osamp(2)); end
    endtask

    task automatic test_gain();
`ifdef GAIN_SCHED_RAMP_EN
        logic [8:0] exp_g [5] = '{9'd0, 9'd1, 9'd2, 9'd3, 9'd3};
        ch_gain[0 +: 9]    = 9'd3;
        ch_sample[0 +: 12] = 12'h010;
        for (int t = 0; t < 5; t++) begin
            logic [8:0] g = 9'h1FF;
            strobe(4'b0001);
            for (int i = 1; i <= 20; i++) begin
                tick();
                if (gu_start) g = gu_gain;
                if (out_valid != '0) break;
            end
            vec++;
            if (g !== exp_g[t]) begin err++; $display("FAIL ramp_gain%0d: got %0d required %0d", t, g, exp_g[t]); end
        end
`else
        logic [8:0] g = 9'h000;
        int k = -1;
        ch_gain[18 +: 9]    = 9'h1FD;
        ch_sample[24 +: 12] = 12'h200;
        strobe(4'b0100);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (gu_start) g = gu_gain;
            if (out_valid != '0) begin
                k = i;
                break;
            end
        end
        vec++;
        if (g !== 9'h1FD) begin err++; $display("FAIL gain_issue: got %h required 1fd", g); end
        vec++;
        if (k !== 8 || osamp(2) !== 12'h6DE) begin
            err++;
            $display("FAIL gain_result: got %0d/%h required 8/6de", k, osamp(2));
        end
        vec++;
        if (gu_gain !== 9'h1FD) begin err++; $display("FAIL gain_hold: got %h required 1fd", gu_gain); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_overrun();
        test_timeout();
        test_reset_mid();
        test_gain();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
